// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks in-flight register writes, forwards the youngest result, and stalls on not-ready hits
module fwd_scoreboard #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int READ_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         adv,
  input  logic [DEPTH-1:0]             flush,
  input  logic                         id_valid,
  input  logic                         id_wen,
  input  logic [ADDR_W-1:0]            id_waddr,
  input  logic [READ_PORTS*ADDR_W-1:0] rd_addr,
  input  logic [READ_PORTS-1:0]        rd_used,
  input  logic [READ_PORTS*DATA_W-1:0] rf_data,
  input  logic [DEPTH*DATA_W-1:0]      slot_data,
  input  logic [DEPTH-1:0]             slot_rdy,
  output logic [READ_PORTS*DATA_W-1:0] fwd_data,
  output logic [READ_PORTS-1:0]        fwd_hit,
  output logic                         stall,
  output logic [DEPTH-1:0]             slot_valid,
  output logic [DEPTH*ADDR_W-1:0]      slot_waddr,
  output logic [31:0]                  stall_cnt
);
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH*ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]             stall_cnt_q, stall_cnt_d;
  logic [READ_PORTS-1:0]   pend;
  logic                    new_v;
  // per-port lookup, scanning oldest to youngest so the youngest match is the last one assigned
  always_comb begin
    fwd_data = rf_data;
    fwd_hit  = '0;
    pend     = '0;
    for (int p = 0; p < READ_PORTS; p++)
      for (int k = DEPTH - 1; k >= 0; k--)
        if (valid_q[k] && waddr_q[k*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W] &&
            rd_addr[p*ADDR_W +: ADDR_W] != '0) begin
          fwd_hit[p]                  = 1'b1;
          fwd_data[p*DATA_W +: DATA_W] = slot_data[k*DATA_W +: DATA_W];
          pend[p]                     = ~slot_rdy[k];
        end
  end
  assign stall = id_valid & |(rd_used & fwd_hit & pend);
  assign new_v = id_valid & id_wen & ~stall & (id_waddr != '0);
  // next slot state: shift on adv (bubble when stalled), hold otherwise, then apply per-slot flush
  always_comb begin
    valid_d = valid_q;
    waddr_d = waddr_q;
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = !adv ? valid_q[k] : (k == 0) ? new_v : valid_q[(k+DEPTH-1)%DEPTH];
      waddr_d[k*ADDR_W +: ADDR_W] = !adv ? waddr_q[k*ADDR_W +: ADDR_W] :
                                    (k == 0) ? id_waddr : waddr_q[((k+DEPTH-1)%DEPTH)*ADDR_W +: ADDR_W];
      if (flush[k]) begin
        valid_d[k]                  = 1'b0;
        waddr_d[k*ADDR_W +: ADDR_W] = '0;
      end
    end
    stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end
  // slot and stall-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      waddr_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      waddr_q     <= waddr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign slot_valid = valid_q;
  assign slot_waddr = waddr_q;
  assign stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed vectors with hand-computed expectations for fwd_scoreboard
module tb_fwd_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n, adv, id_valid, id_wen;
  logic [2:0]  flush, slot_rdy, slot_valid;
  logic [4:0]  id_waddr;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_used, fwd_hit;
  logic [63:0] rf_data, fwd_data;
  logic [95:0] slot_data;
  logic [14:0] slot_waddr;
  logic        stall;
  logic [31:0] stall_cnt;
  int          total = 0;
  int          bad = 0;
  fwd_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .adv(adv), .flush(flush), .id_valid(id_valid), .id_wen(id_wen),
    .id_waddr(id_waddr), .rd_addr(rd_addr), .rd_used(rd_used), .rf_data(rf_data),
    .slot_data(slot_data), .slot_rdy(slot_rdy), .fwd_data(fwd_data), .fwd_hit(fwd_hit),
    .stall(stall), .slot_valid(slot_valid), .slot_waddr(slot_waddr), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] a);
    id_valid = 1'b1; id_wen = 1'b1; id_waddr = a; adv = 1'b1; rd_used = 2'b00;
    tick();
  endtask
  initial begin
    rst_n = 1'b0; adv = 1'b0; flush = '0; id_valid = 1'b0; id_wen = 1'b0; id_waddr = '0;
    rd_addr = '0; rd_used = '0; rf_data = {32'h1111_2222, 32'h3333_4444}; slot_data = '0; slot_rdy = '0;
    tick(); tick();
    #1;
    chk("rst_valid", slot_valid, 3'b000);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fwd", fwd_data, {32'h1111_2222, 32'h3333_4444});
    rst_n = 1'b1;
    tick();
    issue(5'd5);
    id_wen = 1'b0; adv = 1'b0; slot_rdy = 3'b001; slot_data[31:0] = 32'h0000_1234;
    rd_addr = {5'd0, 5'd5}; rd_used = 2'b01; rf_data[31:0] = 32'h0000_DEAD;
    #1;
    chk("exe_data", fwd_data[31:0], 32'h0000_1234);
    chk("exe_hit", fwd_hit, 2'b01);
    chk("exe_stall", stall, 0);
    id_valid = 1'b0; adv = 1'b1; rd_used = 2'b00;
    tick(); tick(); tick();
    chk("drain", slot_valid, 3'b000);
    issue(5'd7);
    id_waddr = 5'd9; rd_addr = {5'd7, 5'd0}; rd_used = 2'b10; slot_rdy = 3'b000;
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_hit", fwd_hit, 2'b10);
    tick();
    chk("lu_valid", slot_valid, 3'b010);
    chk("lu_waddr", slot_waddr[9:5], 5'd7);
    slot_rdy = 3'b010; slot_data[63:32] = 32'hCAFE_F00D;
    #1;
    chk("lu_stall2", stall, 0);
    chk("lu_data", fwd_data[63:32], 32'hCAFE_F00D);
    chk("lu_cnt", stall_cnt, 1);
    issue(5'd3); issue(5'd8); issue(5'd3);
    chk("pri_valid", slot_valid, 3'b111);
    id_valid = 1'b0; adv = 1'b0; slot_data = {32'hB, 32'h0, 32'hA}; slot_rdy = 3'b111;
    rd_addr = {5'd0, 5'd3};
    #1;
    chk("pri_data", fwd_data[31:0], 32'hA);
    chk("pri_hit", fwd_hit, 2'b01);
    id_valid = 1'b1; id_wen = 1'b0; rd_used = 2'b01; slot_rdy = 3'b110;
    #1;
    chk("young_nrdy", stall, 1);
    chk("young_data", fwd_data[31:0], 32'hA);
    rd_used = 2'b00;
    #1;
    chk("unused_port", stall, 0);
    issue(5'd0);
    chk("r0_valid", slot_valid, 3'b110);
    rd_addr = {5'd0, 5'd0}; rd_used = 2'b01; id_valid = 1'b0;
    #1;
    chk("r0_hit", fwd_hit, 2'b00);
    chk("r0_data", fwd_data[31:0], 32'h0000_DEAD);
    issue(5'd3); issue(5'd2); issue(5'd1);
    chk("fl_pre", slot_valid, 3'b111);
    id_waddr = 5'd4; flush = 3'b011;
    tick();
    flush = 3'b000;
    chk("fl_valid", slot_valid, 3'b100);
    chk("fl_waddr", slot_waddr, 15'h0800);
    adv = 1'b0; id_valid = 1'b1; rd_addr = {5'd0, 5'd2}; rd_used = 2'b01; slot_rdy = 3'b000;
    #1;
    chk("hold_stall", stall, 1);
    tick(); tick(); tick();
    chk("hold_valid", slot_valid, 3'b100);
    chk("hold_waddr", slot_waddr, 15'h0800);
    chk("hold_cnt", stall_cnt, 4);
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    tick();
    chk("sat_max", stall_cnt, 32'hFFFF_FFFF);
    tick();
    chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", slot_valid, 3'b000);
    chk("arst_cnt", stall_cnt, 0);
    chk("arst_stall", stall, 0);
    chk("arst_fwd", fwd_data, rf_data);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised operand-forwarding and hazard-detection unit for the pipelined MIPS datapath; successor to the stall-free, forward-free scheme.
- Tracks in-flight register writes across DEPTH post-ID pipeline slots (default EXE/MEM/WB). Serves READ_PORTS source operands from the youngest matching in-flight result, or raises a stall when that result is not yet available (load-use).
- Sits beside ID: the datapath supplies per-slot result data; this block returns forwarded operands, a stall, and a stall counter.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; address 0 is the hard-wired zero register.
- DEPTH, 3, number of tracked slots; slot 0 = youngest (EXE), slot DEPTH-1 = oldest (WB). Legal range 1..8.
- READ_PORTS, 2, number of source operands looked up per cycle. Legal range 1..4.

Ports:
- clk  in  1  main clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- adv  in  1  pipeline advance; slots shift on the edge when high.
- flush  in  DEPTH  per-slot kill; bit k invalidates slot k's post-edge content.
- id_valid  in  1  ID holds a valid instruction.
- id_wen  in  1  ID instruction writes a register.
- id_waddr  in  ADDR_W  ID destination register.
- rd_addr  in  READ_PORTS*ADDR_W  source addresses; port p at bits [p*ADDR_W +: ADDR_W].
- rd_used  in  READ_PORTS  port p operand actually consumed.
- rf_data  in  READ_PORTS*DATA_W  register-file read data per port.
- slot_data  in  DEPTH*DATA_W  result currently held by slot k.
- slot_rdy  in  DEPTH  slot k result is final (0 for a load before MEM).
- fwd_data  out  READ_PORTS*DATA_W  operand to use per port.
- fwd_hit  out  READ_PORTS  port p was forwarded from a slot.
- stall  out  1  ID must hold; a bubble is inserted.
- slot_valid  out  DEPTH  slot k holds a valid writing entry.
- slot_waddr  out  DEPTH*ADDR_W  slot k destination.
- stall_cnt  out  32  saturating count of stall cycles.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately): all slot_valid=0, slot_waddr=0, stall_cnt=0. Hence fwd_hit=0, stall=0, fwd_data=rf_data.
- Slot state: registered {valid, waddr} per slot. Data is never stored here; slot_data/slot_rdy are combinational from the datapath.
- Lookup (combinational, 0-cycle latency), per port p:
  - Slot k matches when slot_valid[k] and slot_waddr[k]==rd_addr[p] and rd_addr[p]!=0.
  - The lowest matching k (youngest) wins.
  - Hit: fwd_hit[p]=1, fwd_data[p]=slot_data[k]. Miss: fwd_hit[p]=0, fwd_data[p]=rf_data[p].
  - Older matches behind a younger match are ignored, even if the younger one is not ready.
- Stall: stall = id_valid & OR over p of (rd_used[p] & hit[p] & ~slot_rdy[winning k]). Unused ports never stall.
- Shift on rising edge when adv=1:
  - slot[0] <= {id_valid & id_wen & ~stall & id_waddr!=0, id_waddr}. With stall=1 a bubble (valid=0) enters.
  - slot[k] <= slot[k-1] for k≥1; slot DEPTH-1 retires.
- Hold: adv=0 keeps all slots unchanged.
- Flush: applied after shift/hold in the same edge. flush[k]=1 forces slot k valid=0 (waddr don't-care, driven 0).
- Simultaneous adv & stall & flush[0]: slot 0 is invalid either way.
- stall_cnt: +1 on each edge where stall=1. Holds at 32'hFFFF_FFFF.
- DEPTH=1: slot 0 is also the retiring slot; the same rules apply.
- Writes to register 0 never enter the scoreboard.

Test Plan:
- Async reset: run with slots valid and stall_cnt=5, pull rst_n low between edges → slot_valid=000, stall_cnt=0, stall=0 before the next edge; fwd_data=rf_data.
- EXE forward (defaults): issue id_wen, id_waddr=5, adv. Next cycle set slot_rdy[0]=1, slot_data[0]=0x0000_1234, rd_addr0=5, rd_used0=1, rf_data0=0xDEAD → fwd_data0=0x1234, fwd_hit0=1, stall=0.
- Load-use: slot0 holds r7 with slot_rdy[0]=0; rd_addr1=7, rd_used1=1, id_valid=1 → stall=1. Edge with adv: slot_valid=010, r7 in slot1. Then slot_rdy[1]=1, slot_data[1]=0xCAFE_F00D → stall=0, fwd_data1=0xCAFEF00D, stall_cnt=1.
- Priority and zero register:
  - slot0 r3 data 0xA, slot2 r3 data 0xB, rd_addr0=3 → fwd_data0=0xA.
  - rd_addr0=0 with slot0 waddr 0 forced via id_waddr=0 → slot stays invalid, fwd_hit0=0.
  - rd_used0=0 with a not-ready match → stall=0.
- Flush: slots 111 (r1,r2,r3), adv=1, flush=3'b011, new issue r4 → after edge slot_valid=100, slot2=r2.
- Hold and saturation: adv=0 for 3 cycles with stall=1 → slots unchanged, stall_cnt +3. Force-preload stall_cnt near max via 2^32 stall cycles in a shortened-width build or by hierarchical deposit of 0xFFFF_FFFE → reaches 0xFFFF_FFFF and holds.
